// File: rtl/issue_queue.sv
// issue_queue: 16-entry reservation station with CDB wakeup, request/grant interface and a registered issue slot.
// Latency: wakeup-to-request 1 cycle; grant-to-issue_valid_OUT 1 cycle; back-to-back issue at one per cycle.
// Backpressure: alloc_ready_OUT drops when all 16 entries are valid; requests_OUT masked while the issue slot is stalled.
//
// Ports:
//   clock_IN, reset_IN (async, active-high), flush_IN (sync squash)
//   alloc_*      : dispatch interface (valid/ready, opcode, dst tag, two source operands)
//   cdb_*        : common data bus broadcast (valid, tag, data)
//   requests_OUT : one request bit per issuable entry, to the arbitration tree
//   grants_IN    : one-hot grant from the tree, same cycle
//   issue_*      : registered issue slot toward the functional unit (valid/ready)
//   occupancy_OUT: count of valid entries, present only when ISSUE_QUEUE_OCCUPANCY_EN is defined
module issue_queue #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int OP_W   = 8
) (
  input  logic              clock_IN,
  input  logic              reset_IN,
  input  logic              flush_IN,
  input  logic              alloc_valid_IN,
  output logic              alloc_ready_OUT,
  input  logic [OP_W-1:0]   alloc_op_IN,
  input  logic [TAG_W-1:0]  alloc_dst_tag_IN,
  input  logic              alloc_src1_rdy_IN,
  input  logic              alloc_src2_rdy_IN,
  input  logic [TAG_W-1:0]  alloc_src1_tag_IN,
  input  logic [TAG_W-1:0]  alloc_src2_tag_IN,
  input  logic [DATA_W-1:0] alloc_src1_val_IN,
  input  logic [DATA_W-1:0] alloc_src2_val_IN,
  input  logic              cdb_valid_IN,
  input  logic [TAG_W-1:0]  cdb_tag_IN,
  input  logic [DATA_W-1:0] cdb_data_IN,
  output logic [15:0]       requests_OUT,
  input  logic [15:0]       grants_IN,
  output logic              issue_valid_OUT,
  input  logic              issue_ready_IN,
  output logic [OP_W-1:0]   issue_op_OUT,
  output logic [TAG_W-1:0]  issue_dst_tag_OUT,
  output logic [DATA_W-1:0] issue_src1_OUT,
  output logic [DATA_W-1:0] issue_src2_OUT
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
  ,
  output logic [4:0]        occupancy_OUT
`endif
);

  localparam int N = 16;

  // Control state (reset) and payload (no reset; only meaningful while valid).
  logic [N-1:0]      valid_q;
  logic [N-1:0]      src1_rdy_q;
  logic [N-1:0]      src2_rdy_q;
  logic [TAG_W-1:0]  src1_tag_q [N];
  logic [TAG_W-1:0]  src2_tag_q [N];
  logic [DATA_W-1:0] src1_val_q [N];
  logic [DATA_W-1:0] src2_val_q [N];
  logic [OP_W-1:0]   op_q       [N];
  logic [TAG_W-1:0]  dst_q      [N];

  logic [3:0]   free_idx;
  logic [3:0]   sel_idx;
  logic         alloc_fire;
  logic         grant_fire;
  logic         slot_open;
  logic [N-1:0] eff_grant;
  logic [N-1:0] wake1;
  logic [N-1:0] wake2;
  logic         alloc_hit1;
  logic         alloc_hit2;

  assign alloc_ready_OUT = ~&valid_q;
  assign alloc_fire      = alloc_valid_IN & alloc_ready_OUT;
  assign slot_open       = !issue_valid_OUT || issue_ready_IN;
  assign requests_OUT    = valid_q & src1_rdy_q & src2_rdy_q & {N{slot_open}};
  // Grant bits on non-requesting entries are masked off; requests already imply slot_open.
  assign eff_grant       = grants_IN & requests_OUT;
  assign grant_fire      = |eff_grant;

  // Operands captured from the CDB in the same cycle they are dispatched.
  assign alloc_hit1 = !alloc_src1_rdy_IN && cdb_valid_IN && (alloc_src1_tag_IN == cdb_tag_IN);
  assign alloc_hit2 = !alloc_src2_rdy_IN && cdb_valid_IN && (alloc_src2_tag_IN == cdb_tag_IN);

  // Lowest free entry and lowest effective grant (scan high to low so the lowest wins).
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (!valid_q[i])   free_idx = 4'(i);
      if (eff_grant[i])  sel_idx  = 4'(i);
    end
  end

  // Tag match per entry; qualified with valid and not-ready where used.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wake1[i] = cdb_valid_IN && valid_q[i] && !src1_rdy_q[i] && (src1_tag_q[i] == cdb_tag_IN);
      wake2[i] = cdb_valid_IN && valid_q[i] && !src2_rdy_q[i] && (src2_tag_q[i] == cdb_tag_IN);
    end
  end

  always_ff @(posedge clock_IN or posedge reset_IN) begin
    if (reset_IN) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
    end else if (flush_IN) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wake1[i]) src1_rdy_q[i] <= 1'b1;
        if (wake2[i]) src2_rdy_q[i] <= 1'b1;
      end
      // The granted entry is valid and the allocated one is free, so they never collide.
      if (grant_fire) valid_q[sel_idx] <= 1'b0;
      if (alloc_fire) begin
        valid_q[free_idx]    <= 1'b1;
        src1_rdy_q[free_idx] <= alloc_src1_rdy_IN | alloc_hit1;
        src2_rdy_q[free_idx] <= alloc_src2_rdy_IN | alloc_hit2;
      end
    end
  end

  always_ff @(posedge clock_IN) begin
    for (int i = 0; i < N; i++) begin
      if (wake1[i]) src1_val_q[i] <= cdb_data_IN;
      if (wake2[i]) src2_val_q[i] <= cdb_data_IN;
    end
    if (alloc_fire) begin
      op_q[free_idx]       <= alloc_op_IN;
      dst_q[free_idx]      <= alloc_dst_tag_IN;
      src1_tag_q[free_idx] <= alloc_src1_tag_IN;
      src2_tag_q[free_idx] <= alloc_src2_tag_IN;
      src1_val_q[free_idx] <= alloc_hit1 ? cdb_data_IN : alloc_src1_val_IN;
      src2_val_q[free_idx] <= alloc_hit2 ? cdb_data_IN : alloc_src2_val_IN;
    end
  end

  // Issue slot: load on grant (also covers accept+grant back-to-back), drain on accept, hold otherwise.
  always_ff @(posedge clock_IN or posedge reset_IN) begin
    if (reset_IN) begin
      issue_valid_OUT   <= 1'b0;
      issue_op_OUT      <= '0;
      issue_dst_tag_OUT <= '0;
      issue_src1_OUT    <= '0;
      issue_src2_OUT    <= '0;
    end else if (flush_IN) begin
      issue_valid_OUT <= 1'b0;
    end else if (grant_fire) begin
      issue_valid_OUT   <= 1'b1;
      issue_op_OUT      <= op_q[sel_idx];
      issue_dst_tag_OUT <= dst_q[sel_idx];
      issue_src1_OUT    <= src1_val_q[sel_idx];
      issue_src2_OUT    <= src2_val_q[sel_idx];
    end else if (issue_ready_IN) begin
      issue_valid_OUT <= 1'b0;
    end
  end

`ifdef ISSUE_QUEUE_OCCUPANCY_EN
  always_ff @(posedge clock_IN or posedge reset_IN) begin
    if (reset_IN) begin
      occupancy_OUT <= '0;
    end else if (flush_IN) begin
      occupancy_OUT <= '0;
    end else begin
      case ({alloc_fire, grant_fire})
        2'b10:   occupancy_OUT <= occupancy_OUT + 5'd1;
        2'b01:   occupancy_OUT <= occupancy_OUT - 5'd1;
        default: occupancy_OUT <= occupancy_OUT;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: self-checking bench for issue_queue.
// Directed sequences and a capture table, then randomized traffic against a behavioural model.
// Inputs are driven 1 time unit after the rising edge; outputs are compared before the next edge.
module tb_issue_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [7:0]  alloc_op;
  logic [5:0]  alloc_dst;
  logic        a_r1, a_r2;
  logic [5:0]  a_t1, a_t2;
  logic [31:0] a_v1, a_v2;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [15:0] requests;
  logic [15:0] grants;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  issue_op;
  logic [5:0]  issue_dst;
  logic [31:0] issue_src1, issue_src2;
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
  logic [4:0]  occupancy;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  issue_queue dut (
    .clock_IN(clk), .reset_IN(reset), .flush_IN(flush),
    .alloc_valid_IN(alloc_valid), .alloc_ready_OUT(alloc_ready),
    .alloc_op_IN(alloc_op), .alloc_dst_tag_IN(alloc_dst),
    .alloc_src1_rdy_IN(a_r1), .alloc_src2_rdy_IN(a_r2),
    .alloc_src1_tag_IN(a_t1), .alloc_src2_tag_IN(a_t2),
    .alloc_src1_val_IN(a_v1), .alloc_src2_val_IN(a_v2),
    .cdb_valid_IN(cdb_valid), .cdb_tag_IN(cdb_tag), .cdb_data_IN(cdb_data),
    .requests_OUT(requests), .grants_IN(grants),
    .issue_valid_OUT(issue_valid), .issue_ready_IN(issue_ready),
    .issue_op_OUT(issue_op), .issue_dst_tag_OUT(issue_dst),
    .issue_src1_OUT(issue_src1), .issue_src2_OUT(issue_src2)
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
    , .occupancy_OUT(occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_occ(input string name, input int exp);
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
    check(name, 64'(occupancy), 64'(exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
    grants      = '0;
    flush       = 1'b0;
  endtask

  // Pulse the asynchronous reset between edges.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic set_alloc(input logic [7:0] op, input logic [5:0] dst,
                           input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                           input logic r2, input logic [5:0] t2, input logic [31:0] v2);
    alloc_valid = 1'b1;
    alloc_op = op; alloc_dst = dst;
    a_r1 = r1; a_t1 = t1; a_v1 = v1;
    a_r2 = r2; a_t2 = t2; a_v2 = v2;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        v;
    bit        r1, r2;
    bit [5:0]  t1, t2;
    bit [31:0] d1, d2;
    bit [7:0]  op;
    bit [5:0]  dst;
  } ent_t;

  ent_t      m [16];
  bit        ms_v;
  bit [7:0]  ms_op;
  bit [5:0]  ms_dst;
  bit [31:0] ms_s1, ms_s2;
  int        m_occ;

  function automatic bit [15:0] m_req(input bit ir);
    bit [15:0] r = '0;
    for (int i = 0; i < 16; i++)
      r[i] = m[i].v && m[i].r1 && m[i].r2 && (!ms_v || ir);
    return r;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 16; i++) if (m[i].v) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i].v = 0;
    ms_v = 0; ms_op = 0; ms_dst = 0; ms_s1 = 0; ms_s2 = 0; m_occ = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int fidx = -1;
    int gk = -1;
    bit [15:0] g;
    bit alloc_ok;
    if (flush) begin
      for (int i = 0; i < 16; i++) m[i].v = 0;
      ms_v = 0;
      m_occ = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (!m[i].v && fidx < 0) fidx = i;
      alloc_ok = alloc_valid && (fidx >= 0);
      g = grants & m_req(issue_ready);
      for (int i = 0; i < 16; i++) if (g[i] && gk < 0) gk = i;
      if (gk >= 0) begin
        ms_v = 1; ms_op = m[gk].op; ms_dst = m[gk].dst;
        ms_s1 = m[gk].d1; ms_s2 = m[gk].d2;
        m[gk].v = 0;
      end else if (issue_ready) begin
        ms_v = 0;
      end
      for (int i = 0; i < 16; i++) begin
        if (m[i].v && cdb_valid && !m[i].r1 && m[i].t1 == cdb_tag) begin m[i].r1 = 1; m[i].d1 = cdb_data; end
        if (m[i].v && cdb_valid && !m[i].r2 && m[i].t2 == cdb_tag) begin m[i].r2 = 1; m[i].d2 = cdb_data; end
      end
      if (alloc_ok) begin
        m[fidx].v = 1; m[fidx].op = alloc_op; m[fidx].dst = alloc_dst;
        m[fidx].t1 = a_t1; m[fidx].t2 = a_t2;
        m[fidx].r1 = a_r1 || (cdb_valid && a_t1 == cdb_tag);
        m[fidx].r2 = a_r2 || (cdb_valid && a_t2 == cdb_tag);
        m[fidx].d1 = (!a_r1 && cdb_valid && a_t1 == cdb_tag) ? cdb_data : a_v1;
        m[fidx].d2 = (!a_r2 && cdb_valid && a_t2 == cdb_tag) ? cdb_data : a_v2;
      end
      m_occ = m_occ + (alloc_ok ? 1 : 0) - (gk >= 0 ? 1 : 0);
    end
  endtask

  // ---------------- dispatch-time capture table ----------------
  typedef struct {
    logic        r1; logic [5:0] t1; logic [31:0] v1;
    logic        r2; logic [5:0] t2; logic [31:0] v2;
    logic        cv; logic [5:0] ct; logic [31:0] cd;
    logic        exp_req;
    logic [31:0] exp_s1, exp_s2;
  } cap_vec_t;

  cap_vec_t cap_tbl [6];

  initial begin
    cap_tbl[0] = '{0, 6'h0A, 32'h0,    1, 6'h00, 32'h11,  1, 6'h0A, 32'h55,       1, 32'h55,       32'h11};
    cap_tbl[1] = '{0, 6'h0A, 32'h0,    1, 6'h00, 32'h11,  1, 6'h0B, 32'h55,       0, 32'h0,        32'h0};
    cap_tbl[2] = '{0, 6'h0A, 32'h0,    1, 6'h00, 32'h11,  0, 6'h0A, 32'h55,       0, 32'h0,        32'h0};
    cap_tbl[3] = '{0, 6'h20, 32'h0,    0, 6'h20, 32'h0,   1, 6'h20, 32'hCAFE,     1, 32'hCAFE,     32'hCAFE};
    cap_tbl[4] = '{1, 6'h20, 32'h1234, 0, 6'h20, 32'h0,   1, 6'h20, 32'hAAAA,     1, 32'h1234,     32'hAAAA};
    cap_tbl[5] = '{1, 6'h01, 32'h42,   0, 6'h3F, 32'h0,   1, 6'h3F, 32'hFFFFFFFF, 1, 32'h42,       32'hFFFFFFFF};
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; flush = 0; alloc_valid = 0; grants = 0; cdb_valid = 0; issue_ready = 0;
    alloc_op = 0; alloc_dst = 0; a_r1 = 0; a_r2 = 0; a_t1 = 0; a_t2 = 0; a_v1 = 0; a_v2 = 0;
    cdb_tag = 0; cdb_data = 0;
    tick();
    do_reset();
    #1;
    check("rst_requests", 64'(requests), 64'h0);
    check("rst_alloc_ready", 64'(alloc_ready), 64'h1);
    check("rst_issue_valid", 64'(issue_valid), 64'h0);
    check("rst_issue_src1", 64'(issue_src1), 64'h0);
    check("rst_issue_op", 64'(issue_op), 64'h0);
    check_occ("rst_occ", 0);

    // Basic allocate / request / grant / issue.
    issue_ready = 1'b1;
    set_alloc(8'h21, 6'h03, 1, 6'h00, 32'd5, 1, 6'h00, 32'd7);
    tick(); idle(); #1;
    check("basic_req", 64'(requests), 64'h0001);
    grants = 16'h0001;
    tick(); idle(); #1;
    check("basic_issue_valid", 64'(issue_valid), 64'h1);
    check("basic_src1", 64'(issue_src1), 64'd5);
    check("basic_src2", 64'(issue_src2), 64'd7);
    check("basic_op", 64'(issue_op), 64'h21);
    check("basic_dst", 64'(issue_dst), 64'h03);
    check("basic_entry_freed", 64'(requests), 64'h0);
    set_alloc(8'h22, 6'h04, 1, 6'h00, 32'd9, 1, 6'h00, 32'd9);
    tick(); idle(); #1;
    check("basic_entry0_reused", 64'(requests), 64'h0001);
    check_occ("basic_occ", 1);

    // Delayed CDB wakeup.
    tick(); do_reset();
    issue_ready = 1'b1;
    set_alloc(8'h30, 6'h05, 0, 6'h12, 32'h0, 1, 6'h00, 32'd9);
    tick(); idle(); #1;
    check("wake_wait0", 64'(requests), 64'h0);
    tick();
    cdb_valid = 1; cdb_tag = 6'h12; cdb_data = 32'hDEADBEEF;
    #1;
    check("wake_same_cycle", 64'(requests), 64'h0);
    tick(); idle(); #1;
    check("wake_req", 64'(requests), 64'h0001);
    grants = 16'h0001;
    tick(); idle(); #1;
    check("wake_src1", 64'(issue_src1), 64'hDEADBEEF);
    check("wake_src2", 64'(issue_src2), 64'd9);

    // Dispatch-time capture table.
    foreach (cap_tbl[k]) begin
      tick(); do_reset();
      issue_ready = 1'b1;
      set_alloc(8'(k), 6'(k), cap_tbl[k].r1, cap_tbl[k].t1, cap_tbl[k].v1,
                cap_tbl[k].r2, cap_tbl[k].t2, cap_tbl[k].v2);
      cdb_valid = cap_tbl[k].cv; cdb_tag = cap_tbl[k].ct; cdb_data = cap_tbl[k].cd;
      tick(); idle(); #1;
      check($sformatf("cap%0d_req", k), 64'(requests), {63'b0, cap_tbl[k].exp_req});
      if (cap_tbl[k].exp_req) begin
        grants = 16'h0001;
        tick(); idle(); #1;
        check($sformatf("cap%0d_src1", k), 64'(issue_src1), 64'(cap_tbl[k].exp_s1));
        check($sformatf("cap%0d_src2", k), 64'(issue_src2), 64'(cap_tbl[k].exp_s2));
      end
    end

    // Fill all 16 entries, drop a 17th, free entry 3 and refill it.
    tick(); do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_alloc(8'(i), 6'(i), 1, 6'h00, 32'(i), 1, 6'h00, 32'(i + 100));
      tick();
    end
    set_alloc(8'hEE, 6'h3E, 1, 6'h00, 32'h99, 1, 6'h00, 32'h99);
    #1;
    check("full_alloc_ready", 64'(alloc_ready), 64'h0);
    check("full_requests", 64'(requests), 64'hFFFF);
    check_occ("full_occ16", 16);
    tick(); idle();
    grants = 16'h0008;
    #1;
    check("full_drop_still_full", 64'(alloc_ready), 64'h0);
    tick(); idle(); #1;
    check("full_ready_after_grant", 64'(alloc_ready), 64'h1);
    check("full_req_after_grant", 64'(requests), 64'hFFF7);
    check("full_issue_e3", 64'(issue_src1), 64'd3);
    check_occ("full_occ15", 15);
    set_alloc(8'h77, 6'h37, 1, 6'h00, 32'h77, 1, 6'h00, 32'h78);
    tick(); idle(); #1;
    check("refill_alloc_ready", 64'(alloc_ready), 64'h0);
    check("refill_requests", 64'(requests), 64'hFFFF);
    check_occ("refill_occ16", 16);
    grants = 16'h0008;
    tick(); idle(); #1;
    check("refill_in_entry3", 64'(issue_src1), 64'h77);

    // Stalled issue slot holds and masks requests; then back-to-back reload.
    issue_ready = 1'b0;
    #1;
    check("stall_requests", 64'(requests), 64'h0);
    grants = 16'h0010;
    tick(); idle(); #1;
    check("stall_hold_valid", 64'(issue_valid), 64'h1);
    check("stall_hold_src1", 64'(issue_src1), 64'h77);
    issue_ready = 1'b1;
    grants = 16'h0010;
    #1;
    check("unstall_requests", 64'(requests), 64'hFFF7);
    tick(); idle(); #1;
    check("b2b_src1_e4", 64'(issue_src1), 64'd4);
    check("b2b_valid", 64'(issue_valid), 64'h1);
    check("b2b_requests", 64'(requests), 64'hFFE7);
    grants = 16'h0008;
    tick(); idle(); #1;
    check("ignored_grant_drains", 64'(issue_valid), 64'h0);
    grants = 16'h0030;
    tick(); idle(); #1;
    check("multi_grant_lowest", 64'(issue_src1), 64'd5);
    check("multi_grant_op", 64'(issue_op), 64'd5);
    check("multi_grant_req", 64'(requests), 64'hFFC7);

    // Asynchronous reset mid-operation, checked before the next edge.
    reset = 1'b1;
    #1;
    check("async_rst_requests", 64'(requests), 64'h0);
    check("async_rst_alloc_ready", 64'(alloc_ready), 64'h1);
    check("async_rst_issue_valid", 64'(issue_valid), 64'h0);
    check("async_rst_src1", 64'(issue_src1), 64'h0);
    reset = 1'b0;

    // Flush with simultaneous allocate and grant.
    tick();
    issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_alloc(8'(i), 6'(i), 1, 6'h00, 32'(i), 1, 6'h00, 32'(i));
      tick();
    end
    idle(); #1;
    check("flush_pre_requests", 64'(requests), 64'h001F);
    flush = 1'b1;
    set_alloc(8'h50, 6'h10, 1, 6'h00, 32'h50, 1, 6'h00, 32'h50);
    grants = 16'h0001;
    tick(); idle(); #1;
    check("flush_requests", 64'(requests), 64'h0);
    check("flush_issue_valid", 64'(issue_valid), 64'h0);
    check("flush_alloc_ready", 64'(alloc_ready), 64'h1);
    check_occ("flush_occ", 0);
    tick(); #1;
    check("flush_alloc_dropped", 64'(requests), 64'h0);

    // Randomized traffic against the model.
    tick(); do_reset(); model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      flush       = ($urandom_range(63, 0) == 0);
      issue_ready = ($urandom_range(9, 0) < 7);
      cdb_valid   = $urandom_range(1, 0);
      cdb_tag     = 6'($urandom_range(7, 0));
      cdb_data    = $urandom;
      if ($urandom_range(1, 0) == 1) grants = 16'(1) << $urandom_range(15, 0);
      else                           grants = 16'($urandom);
      if ($urandom_range(9, 0) < 6)
        set_alloc(8'($urandom), 6'($urandom), 1'($urandom_range(1, 0)), 6'($urandom_range(7, 0)), $urandom,
                  1'($urandom_range(1, 0)), 6'($urandom_range(7, 0)), $urandom);
      else
        alloc_valid = 1'b0;
      #1;
      check("rnd_requests", 64'(requests), 64'(m_req(issue_ready)));
      check("rnd_alloc_ready", 64'(alloc_ready), 64'(m_count() < 16));
      check("rnd_issue_valid", 64'(issue_valid), 64'(ms_v));
      if (ms_v) begin
        check("rnd_issue_op", 64'(issue_op), 64'(ms_op));
        check("rnd_issue_dst", 64'(issue_dst), 64'(ms_dst));
        check("rnd_issue_src1", 64'(issue_src1), 64'(ms_s1));
        check("rnd_issue_src2", 64'(issue_src2), 64'(ms_s2));
      end
      check_occ("rnd_occ", m_occ);
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
